// File: rtl/alu_issue.sv
// Issue/handshake controller in front of the ALU: captures one request, pulses ALU_en, waits for
// ALU_vld and holds the result for downstream. Optional WAIT timeout: AXIS_CPU_ALU_TIMEOUT_EN.
module alu_issue #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_vld,
   output logic        in_rdy,
   input  logic [31:0] in_A,
   input  logic [31:0] in_B,
   input  logic [3:0]  in_sel,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [3:0]  ALU_sel,
   output logic        ALU_en,
   input  logic [31:0] ALU_out,
   input  logic        ALU_vld,
   output logic        ALU_ack,
   input  logic        eq,
   input  logic        gt,
   input  logic        ge,
   input  logic        set,
   output logic        out_vld,
   input  logic        out_rdy,
   output logic [31:0] out_res,
   output logic [3:0]  out_flags,
   output logic        out_err,
   output logic        busy
);

   localparam logic [31:0] ErrRes = 32'h2BADDEAD;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]  sel_q, sel_d, flags_q, flags_d;
   logic        err_q, err_d, vld_q, busy_q;
   logic        capture;

`ifdef AXIS_CPU_ALU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout;

   assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      res_d   = res_q;
      flags_d = flags_q;
      err_d   = err_q;
      capture = 1'b0;
`ifdef AXIS_CPU_ALU_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_vld) capture = 1'b1;
         end
         StIssue: begin
            state_d = StWait;
`ifdef AXIS_CPU_ALU_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         StWait: begin
`ifdef AXIS_CPU_ALU_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (ALU_vld) begin
               res_d   = ALU_out;
               flags_d = {set, ge, gt, eq};
               err_d   = 1'b0;
               state_d = StHold;
            end
`ifdef AXIS_CPU_ALU_TIMEOUT_EN
            else if (timeout) begin
               // A late ALU_vld for this op is drained by the unconditional ack.
               res_d   = ErrRes;
               flags_d = '0;
               err_d   = 1'b1;
               state_d = StHold;
            end
`endif
         end
         StHold: begin
            if (out_rdy) begin
               if (in_vld) capture = 1'b1;
               else        state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (capture) begin
         a_d   = in_A;
         b_d   = in_B;
         sel_d = in_sel;
         if (in_sel <= 4'd10) begin
            state_d = StIssue;
         end else begin
            res_d   = ErrRes;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = StHold;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         res_q   <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         err_q   <= err_d;
         vld_q   <= (state_d == StHold);
         busy_q  <= (state_d != StIdle);
      end
   end

`ifdef AXIS_CPU_ALU_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`endif

   // rst gating keeps the combinational outputs at 0 while reset is held.
   assign in_rdy  = rst & ((state_q == StIdle) | ((state_q == StHold) & out_rdy));
   assign ALU_en  = (state_q == StIssue);
   // Acking in every state also drains stale results from ops cut off by reset or timeout.
   assign ALU_ack = rst & ALU_vld;

   assign A         = a_q;
   assign B         = b_q;
   assign ALU_sel   = sel_q;
   assign out_vld   = vld_q;
   assign out_res   = res_q;
   assign out_flags = flags_q;
   assign out_err   = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU (1-cycle ops, 3-cycle MUL, 6-cycle DIV/MOD).
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_vld = 1'b0, in_rdy;
   logic [31:0] in_A = '0, in_B = '0;
   logic [3:0]  in_sel = '0;
   logic [31:0] A, B;
   logic [3:0]  ALU_sel;
   logic        ALU_en, ALU_ack;
   logic [31:0] m_out = '0;
   logic        m_vld = 1'b0, m_eq = 1'b0, m_gt = 1'b0, m_ge = 1'b0, m_set = 1'b0;
   logic        out_vld, out_rdy = 1'b0, out_err, busy;
   logic [31:0] out_res;
   logic [3:0]  out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_A      (in_A),
      .in_B      (in_B),
      .in_sel    (in_sel),
      .A         (A),
      .B         (B),
      .ALU_sel   (ALU_sel),
      .ALU_en    (ALU_en),
      .ALU_out   (m_out),
      .ALU_vld   (m_vld),
      .ALU_ack   (ALU_ack),
      .eq        (m_eq),
      .gt        (m_gt),
      .ge        (m_ge),
      .set       (m_set),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_res   (out_res),
      .out_flags (out_flags),
      .out_err   (out_err),
      .busy      (busy)
   );

   // Behavioural ALU; not reset, so an op cut off by reset still delivers a late result.
   function automatic int lat_of(input logic [3:0] s);
      if (s == 4'd8) return 3;
      if (s == 4'd9 || s == 4'd10) return 6;
      return 1;
   endfunction

   function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd8:    return a * b;
         4'd9:    return (b != 0) ? a / b : 32'hFFFF_FFFF;
         4'd10:   return (b != 0) ? a % b : a;
         default: return a;
      endcase
   endfunction

   logic        m_pend = 1'b0;
   logic        alu_hang = 1'b0;
   int          m_cnt = 0;
   int          stable_bad = 0;
   logic [31:0] a0 = '0, b0 = '0;
   logic        fire;

   assign fire = (ALU_en && lat_of(ALU_sel) == 1) ||
                 (!ALU_en && m_pend && !alu_hang && m_cnt == 1);

   always @(posedge clk) begin
      if (m_vld && ALU_ack) m_vld <= 1'b0;
      if (ALU_en) begin
         a0 <= A;
         b0 <= B;
         if (lat_of(ALU_sel) != 1) begin
            m_pend <= 1'b1;
            m_cnt  <= lat_of(ALU_sel) - 1;
         end
      end else if (m_pend) begin
         if (A !== a0 || B !== b0) stable_bad <= stable_bad + 1;
         if (fire)           m_pend <= 1'b0;
         else if (m_cnt > 1) m_cnt  <= m_cnt - 1;
      end
      if (fire) begin
         m_vld <= 1'b1;
         m_out <= calc(A, B, ALU_sel);
         m_eq  <= (A == B);
         m_gt  <= (A > B);
         m_ge  <= (A >= B);
         m_set <= (calc(A, B, ALU_sel) != 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic request(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      in_vld = 1'b1;
      in_A   = a;
      in_B   = b;
      in_sel = s;
   endtask

   task automatic wait_out(input int max, input string tag);
      int n = 0;
      while (!out_vld && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, out_vld}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      @(negedge clk);
      #1;
      check("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("rst_out_vld", {31'd0, out_vld}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("idle_in_rdy", {31'd0, in_rdy}, 32'd1);

      // ADD 5+3: ALU_en at T+1, ack at T+2, out_vld at T+3
      out_rdy = 1'b1;
      request(32'd5, 32'd3, 4'd0);
      @(negedge clk);
      in_vld = 1'b0;
      check("add_en_t1", {31'd0, ALU_en}, 32'd1);
      check("add_a_held", A, 32'd5);
      @(negedge clk);
      check("add_ack_t2", {31'd0, ALU_ack}, 32'd1);
      check("add_vld_t2", {31'd0, out_vld}, 32'd0);
      @(negedge clk);
      check("add_vld_t3", {31'd0, out_vld}, 32'd1);
      check("add_res", out_res, 32'd8);
      check("add_flags", {28'd0, out_flags}, 32'b1110);
      check("add_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
      check("add_drop_vld", {31'd0, out_vld}, 32'd0);
      check("add_idle_busy", {31'd0, busy}, 32'd0);

      // DIV then MOD, operands must stay put for the whole wait
      request(32'd100, 32'd7, 4'd9);
      @(negedge clk);
      in_vld = 1'b0;
      wait_out(20, "div_done");
      check("div_res", out_res, 32'd14);
      check("div_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
      request(32'd100, 32'd7, 4'd10);
      @(negedge clk);
      in_vld = 1'b0;
      wait_out(20, "mod_done");
      check("mod_res", out_res, 32'd2);
      check("divmod_operands_stable", stable_bad, 32'd0);
      @(negedge clk);

      // MUL 6*7
      request(32'd6, 32'd7, 4'd8);
      @(negedge clk);
      in_vld = 1'b0;
      wait_out(20, "mul_done");
      check("mul_res", out_res, 32'd42);
      check("mul_flags", {28'd0, out_flags}, 32'b1000);
      @(negedge clk);

      // Backpressure in HOLD, then same-cycle handoff of the next request
      out_rdy = 1'b0;
      request(32'd10, 32'd4, 4'd1);
      @(negedge clk);
      in_vld = 1'b0;
      wait_out(20, "sub_done");
      check("sub_res", out_res, 32'd6);
      request(32'd7, 32'd9, 4'd0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
         check("hold_out_vld", {31'd0, out_vld}, 32'd1);
         check("hold_res", out_res, 32'd6);
         @(negedge clk);
      end
      out_rdy = 1'b1;
      #1;
      check("hold_accept_rdy", {31'd0, in_rdy}, 32'd1);
      @(negedge clk);
      in_vld = 1'b0;
      check("handoff_en", {31'd0, ALU_en}, 32'd1);
      check("handoff_a", A, 32'd7);
      check("handoff_vld_drop", {31'd0, out_vld}, 32'd0);
      wait_out(20, "handoff_done");
      check("handoff_res", out_res, 32'd16);
      check("handoff_flags", {28'd0, out_flags}, 32'b1000);
      @(negedge clk);

      // Illegal opcode: no ALU_en, error result at T+1
      request(32'd1, 32'd2, 4'd12);
      @(negedge clk);
      in_vld = 1'b0;
      check("ill_no_en", {31'd0, ALU_en}, 32'd0);
      check("ill_vld_t1", {31'd0, out_vld}, 32'd1);
      check("ill_res", out_res, 32'h2BADDEAD);
      check("ill_err", {31'd0, out_err}, 32'd1);
      check("ill_flags", {28'd0, out_flags}, 32'd0);
      @(negedge clk);
      check("ill_done", {31'd0, out_vld}, 32'd0);

      // Reset during a DIV wait, then drain the late result in IDLE
      request(32'd50, 32'd5, 4'd9);
      @(negedge clk);
      in_vld = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_a", A, 32'd0);
      check("arst_sel", {28'd0, ALU_sel}, 32'd0);
      check("arst_res", out_res, 32'd0);
      check("arst_err", {31'd0, out_err}, 32'd0);
      check("arst_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("arst_en", {31'd0, ALU_en}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 20 && !m_vld; n++) @(negedge clk);
      check("late_vld_seen", {31'd0, m_vld}, 32'd1);
      check("late_ack", {31'd0, ALU_ack}, 32'd1);
      @(negedge clk);
      check("late_drained", {31'd0, m_vld}, 32'd0);
      check("late_no_out", {31'd0, out_vld}, 32'd0);
      check("late_not_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);

`ifdef AXIS_CPU_ALU_TIMEOUT_EN
      // ALU never answers: error result after 8 WAIT cycles
      begin
         int n = 0;
         alu_hang = 1'b1;
         request(32'd1, 32'd1, 4'd9);
         @(negedge clk);
         in_vld = 1'b0;
         check("to_en", {31'd0, ALU_en}, 32'd1);
         while (!out_vld && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("to_latency", n, 32'd9);
         check("to_vld", {31'd0, out_vld}, 32'd1);
         check("to_err", {31'd0, out_err}, 32'd1);
         check("to_res", out_res, 32'h2BADDEAD);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
